// File: rtl/data_memory_responder_pkg.sv
// data_mem_pkg: shared encodings for the MEM-stage data memory responder.
package data_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic RW_LOAD = 1'b0;
  localparam logic RW_STORE = 1'b1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: MEM-stage request/response bundle for the data memory.
interface data_memory_responder_if #(parameter int ADDR_W = 9);
  logic DataMem_enable;
  logic Read_Write;
  logic [1:0] size_dm;
  logic SE_dm;
  logic [ADDR_W-1:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic stall;
  logic done;
  logic misalign;
  modport master(output DataMem_enable, Read_Write, size_dm, SE_dm, Address, DataIn,
                 input DataOut, stall, done, misalign);
  modport slave(input DataMem_enable, Read_Write, size_dm, SE_dm, Address, DataIn,
                output DataOut, stall, done, misalign);
endinterface

// File: rtl/data_memory_responder_load_formatter.sv
// dm_load_formatter: picks byte/halfword/word from a big-endian fetch and sign/zero extends it.
module dm_load_formatter import data_mem_pkg::*; (
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        se,
  output logic [31:0] data
);
  always_comb data = size == SZ_BYTE ? {{24{se & raw[31]}}, raw[31:24]} :
                     size == SZ_HALF ? {{16{se & raw[31]}}, raw[31:16]} : raw;
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: wait-stated big-endian data memory; DM_MISALIGN_TRAP_EN enables alignment faults.
module data_memory_responder import data_mem_pkg::*; #(
  parameter int ADDR_W = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic Clk,
  input logic R,
  data_memory_responder_if.slave bus
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [7:0] Mem [2**ADDR_W];
  state_t state;
  logic [CW-1:0] cnt;
  logic rw_q, se_q;
  logic [1:0] sz_q;
  logic [ADDR_W-1:0] a_q;
  logic [31:0] d_q, dout_q;
  logic done_q, mis_q;
  logic idle, accept, rw, se, half, word, trap, fire;
  logic [1:0] sz;
  logic [ADDR_W-1:0] a, ea;
  logic [31:0] d, raw, fmt;
  // In IDLE the live request is used so a zero-wait or trapped access resolves on the accept edge.
  always_comb begin
    idle = state == IDLE;
    accept = idle && bus.DataMem_enable;
    rw = idle ? bus.Read_Write : rw_q;
    se = idle ? bus.SE_dm : se_q;
    sz = idle ? bus.size_dm : sz_q;
    a = idle ? bus.Address : a_q;
    d = idle ? bus.DataIn : d_q;
    half = sz == SZ_HALF;
    word = sz[1];
`ifdef DM_MISALIGN_TRAP_EN
    trap = (half && a[0]) || (word && a[1:0] != 2'b00);
    ea = a;
`else
    trap = 1'b0;
    ea = {a[ADDR_W-1:2], word ? 2'b00 : {a[1], half ? 1'b0 : a[0]}};
`endif
    raw = {Mem[ea], Mem[ea + ADDR_W'(1)], Mem[ea + ADDR_W'(2)], Mem[ea + ADDR_W'(3)]};
    fire = (accept && !trap && WAIT_CYCLES == 0) || (state == WAIT && cnt == CW'(1));
  end
  dm_load_formatter u_fmt (.raw(raw), .size(sz), .se(se), .data(fmt));
  always_ff @(posedge Clk) begin
    if (fire && rw == RW_STORE && !R) begin
      Mem[ea] <= half ? d[15:8] : word ? d[31:24] : d[7:0];
      if (half || word) Mem[ea + ADDR_W'(1)] <= half ? d[7:0] : d[23:16];
      if (word) begin
        Mem[ea + ADDR_W'(2)] <= d[15:8];
        Mem[ea + ADDR_W'(3)] <= d[7:0];
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (R) begin
      state <= IDLE;
      cnt <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      done_q <= fire || (accept && trap);
      mis_q <= accept && trap;
      if (fire && rw == RW_LOAD) dout_q <= fmt;
      if (accept && trap) dout_q <= '0;
      case (state)
        IDLE: if (bus.DataMem_enable) begin
          rw_q <= bus.Read_Write;
          se_q <= bus.SE_dm;
          sz_q <= bus.size_dm;
          a_q <= bus.Address;
          d_q <= bus.DataIn;
          cnt <= CW'(WAIT_CYCLES);
          state <= (trap || WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.DataOut = dout_q;
  assign bus.done = done_q;
  assign bus.misalign = mis_q;
  assign bus.stall = !R && (accept || state == WAIT);
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: random and directed load/store checks against a byte-array model.
module tb_data_memory_responder;
  import data_mem_pkg::*;
  localparam int AW = 9;
  localparam int W = 2;
  localparam int DEPTH = 1 << AW;
  logic Clk = 1'b0;
  logic R = 1'b1;
  always #5 Clk = ~Clk;
  data_memory_responder_if #(.ADDR_W(AW)) bus ();
  data_memory_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (.Clk(Clk), .R(R), .bus(bus));
  logic [7:0] mm [DEPTH];
  logic [31:0] last_out = '0;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic bit trap_of(input logic [1:0] sz, input int a);
`ifdef DM_MISALIGN_TRAP_EN
    return a % nbytes(sz) != 0;
`else
    return sz != sz;
`endif
  endfunction
  function automatic int base_of(input logic [1:0] sz, input int a);
`ifdef DM_MISALIGN_TRAP_EN
    return a;
`else
    return a - a % nbytes(sz);
`endif
  endfunction
  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit se, input int a);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    int b = base_of(sz, a);
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[(b + i) % DEPTH]);
    if (se && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction
  task automatic model_store(input logic [1:0] sz, input int a, input logic [31:0] d);
    int n = nbytes(sz);
    int b = base_of(sz, a);
    for (int i = 0; i < n; i++) mm[(b + i) % DEPTH] = 8'(d >> (8 * (n - 1 - i)));
  endtask
  task automatic xact(input string tag, input bit rw, input logic [1:0] sz, input bit se,
                      input int a, input logic [31:0] d, input bit hold);
    bit tr = trap_of(sz, a);
    int lat = tr ? 1 : W + 1;
    int stalls = 0;
    int done_at = -1;
    logic mis = 1'b0;
    logic [31:0] out = '0;
    logic [31:0] exp = tr ? 32'h0 : rw ? last_out : model_load(sz, se, a);
    @(negedge Clk);
    bus.Read_Write = rw;
    bus.size_dm = sz;
    bus.SE_dm = se;
    bus.Address = AW'(a);
    bus.DataIn = d;
    bus.DataMem_enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.stall) stalls++;
      if (bus.done) begin
        done_at = c;
        mis = bus.misalign;
        out = bus.DataOut;
        break;
      end
      if (!hold && c >= 1) bus.DataMem_enable = 1'b0;
      @(negedge Clk);
    end
    bus.DataMem_enable = 1'b0;
    chk({tag, "/latency"}, 32'(done_at), 32'(lat));
    chk({tag, "/stall_cycles"}, 32'(stalls), 32'(lat));
    chk({tag, "/misalign"}, 32'(mis), 32'(tr));
    chk({tag, "/data"}, out, exp);
    if (rw && !tr) model_store(sz, a, d);
    last_out = exp;
    @(negedge Clk);
    #1;
    chk({tag, "/done_pulse"}, 32'(bus.done), 32'h0);
    chk({tag, "/hold"}, bus.DataOut, exp);
    chk({tag, "/idle_stall"}, 32'(bus.stall), 32'h0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int dn;
    bus.DataMem_enable = 1'b1;
    bus.Read_Write = 1'b0;
    bus.size_dm = 2'd0;
    bus.SE_dm = 1'b0;
    bus.Address = '0;
    bus.DataIn = '0;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst/stall", 32'(bus.stall), 32'h0);
    chk("rst/done", 32'(bus.done), 32'h0);
    chk("rst/data", bus.DataOut, 32'h0);
    chk("rst/misalign", 32'(bus.misalign), 32'h0);
    R = 1'b0;
    bus.DataMem_enable = 1'b0;
    for (int a = 0; a < DEPTH; a += 4) xact("fill", 1'b1, SZ_WORD, 1'b0, a, $urandom, 1'b0);
    xact("st_word", 1'b1, SZ_WORD, 1'b0, 'h010, 32'hA1B2C3D4, 1'b1);
    xact("ld_word", 1'b0, SZ_WORD, 1'b0, 'h010, 32'h0, 1'b0);
    chk("mem010", 32'(dut.Mem[16]), 32'hA1);
    chk("mem013", 32'(dut.Mem[19]), 32'hD4);
    xact("ld_byte_se", 1'b0, SZ_BYTE, 1'b1, 'h010, 32'h0, 1'b0);
    xact("ld_byte_ze", 1'b0, SZ_BYTE, 1'b0, 'h010, 32'h0, 1'b1);
    xact("st_half", 1'b1, SZ_HALF, 1'b0, 'h012, 32'h00001234, 1'b0);
    xact("ld_merge", 1'b0, SZ_WORD, 1'b0, 'h010, 32'h0, 1'b0);
    xact("ld_half_se", 1'b0, SZ_HALF, 1'b1, 'h010, 32'h0, 1'b0);
    xact("ld_size3", 1'b0, 2'b11, 1'b1, 'h010, 32'h0, 1'b0);
    xact("ld_mis", 1'b0, SZ_WORD, 1'b0, 'h011, 32'h0, 1'b0);
    xact("st_mis", 1'b1, SZ_HALF, 1'b0, 'h013, 32'hFFFF9988, 1'b0);
    xact("ld_after_mis", 1'b0, SZ_WORD, 1'b0, 'h010, 32'h0, 1'b0);
    @(negedge Clk);
    bus.Read_Write = 1'b1;
    bus.size_dm = SZ_WORD;
    bus.Address = AW'('h020);
    bus.DataIn = 32'h55AA55AA;
    bus.DataMem_enable = 1'b1;
    @(negedge Clk);
    bus.DataMem_enable = 1'b0;
    R = 1'b1;
    #1;
    chk("abort/stall", 32'(bus.stall), 32'h0);
    @(negedge Clk);
    R = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge Clk);
      #1;
      dn += int'(bus.done) + int'(bus.stall);
    end
    chk("abort/done_stall", 32'(dn), 32'h0);
    for (int i = 0; i < 4; i++) chk("abort/mem", 32'(dut.Mem[32 + i]), 32'(mm[32 + i]));
    last_out = 32'h0;
    xact("abort/ld", 1'b0, SZ_WORD, 1'b0, 'h020, 32'h0, 1'b0);
    for (int i = 0; i < 100; i++)
      xact("rand", 1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(DEPTH - 1)),
           $urandom, 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
